reference_buffer_sequencer: RTL and testbench

Controller that sweeps reference_buffer addresses 0..BUFFER_LENGTH-1 over its AXI-style read handshake, for a programmed number of passes (one pass per CAF frequency bin). It forwards returned I/Q samples downstream through a small credit-managed FIFO and tags each sample with pass-last and final-last markers. It sits between the CAF top-level control and the reference_buffer read port.

---
 rtl/reference_buffer_sequencer_pkg.sv | 9 +
 rtl/reference_buffer_sequencer_fifo.sv | 35 +++
 rtl/reference_buffer_sequencer.sv | 99 +++++++++
 tb/tb_reference_buffer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reference_buffer_sequencer_pkg.sv
// reference_buffer_sequencer_pkg: shared state encoding, FIFO sizing and tag layout
package reference_buffer_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_BITS = 3;
  localparam int TAG_BITS = 2;
  localparam int TAG_LAST = 1;
  localparam int TAG_FINAL = 0;
endpackage

// File: rtl/reference_buffer_sequencer_fifo.sv
// sample_tag_fifo: 4-entry synchronous FIFO with occupancy count
module sample_tag_fifo
  import reference_buffer_sequencer_pkg::*;
#(
  parameter int W = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic [CNT_BITS-1:0] count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CNT_BITS'(FIFO_DEPTH) || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end
endmodule

// File: rtl/reference_buffer_sequencer.sv
// reference_buffer_sequencer: multi-pass address sweep with credit-managed, tagged sample forwarding
module reference_buffer_sequencer
  import reference_buffer_sequencer_pkg::*;
#(
  parameter int BUFFER_LENGTH = 16,
  parameter int INDEX_BITS = 4,
  parameter int I_BITS = 12,
  parameter int Q_BITS = 12,
  parameter int PASS_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PASS_BITS-1:0]  num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [INDEX_BITS-1:0] m_axi_raddr,
  output logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  s_axi_rready,
  input  logic                  s_axi_rvalid,
  input  logic [I_BITS-1:0]     i,
  input  logic [Q_BITS-1:0]     q,
  output logic [I_BITS-1:0]     out_i,
  output logic [Q_BITS-1:0]     out_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_final
);
  localparam int DW = I_BITS + Q_BITS + TAG_BITS;
  state_t state, state_n;
  logic [INDEX_BITS-1:0] addr;
  logic [PASS_BITS-1:0] pass, npass;
  logic [CNT_BITS-1:0] outstanding, fifo_count;
  logic [TAG_BITS-1:0] tag, tag_head;
  logic [DW-1:0] head;
  logic accept, data_accept, last, fin;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign m_axi_rready = busy;
  assign m_axi_raddr = addr;
  // Credits cover both in-flight reads and buffered samples, so the FIFO can never overflow
  assign m_axi_rvalid = state == RUN && ({1'b0, outstanding} + {1'b0, fifo_count}) < 4'(FIFO_DEPTH);
  assign accept = m_axi_rvalid && s_axi_rready;
  assign data_accept = s_axi_rvalid && m_axi_rready;
  assign last = addr == INDEX_BITS'(BUFFER_LENGTH - 1);
  assign fin = last && pass == npass - 1'b1;
  assign tag[TAG_LAST] = last;
  assign tag[TAG_FINAL] = fin;
  assign out_valid = fifo_count != '0;
  assign {out_i, out_q, out_last, out_final} = out_valid ? head : '0;
  // The tag queue occupancy doubles as the outstanding-read count
  sample_tag_fifo #(.W(TAG_BITS)) u_tag_q (
    .clk(clk),
    .reset(reset),
    .push(accept),
    .pop(data_accept),
    .din(tag),
    .dout(tag_head),
    .count(outstanding)
  );
  sample_tag_fifo #(.W(DW)) u_data_q (
    .clk(clk),
    .reset(reset),
    .push(data_accept),
    .pop(out_valid && out_ready),
    .din({i, q, tag_head}),
    .dout(head),
    .count(fifo_count)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = start ? (num_passes == '0 ? DONE : RUN) : IDLE;
      RUN: state_n = accept && fin ? DRAIN : RUN;
      DRAIN: state_n = outstanding == '0 && fifo_count == '0 ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      pass <= '0;
      npass <= '0;
    end else if (state == IDLE && start) begin
      npass <= num_passes;
      addr <= '0;
      pass <= '0;
    end else if (accept) begin
      addr <= last ? '0 : addr + 1'b1;
      if (last) pass <= pass + 1'b1;
    end
  end
endmodule

// File: tb/tb_reference_buffer_sequencer.sv
// tb_reference_buffer_sequencer: directed scenario tests against a latency-1 buffer responder
module tb_reference_buffer_sequencer;
  localparam int BL = 8;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] num_passes = 0;
  logic busy, done, m_axi_rvalid, m_axi_rready;
  logic [2:0] m_axi_raddr;
  logic s_axi_rready = 1, s_axi_rvalid = 0;
  logic [11:0] i, q, out_i, out_q;
  logic [2:0] resp_k = 0;
  logic out_valid, out_ready = 1, out_last, out_final;
  logic rand_mode = 0, stray = 0;
  int pass_cnt = 0, total = 0;
  int cyc = 0, st_cyc = 0, dn_cyc = 0, done_cnt = 0, rv_cnt = 0, stab_err = 0;
  logic pv = 0, pr = 0;
  logic [2:0] pa = 0;
  logic [25:0] oq[$];
  int tq[$];
  logic [2:0] aq[$];

  reference_buffer_sequencer #(
    .BUFFER_LENGTH(BL), .INDEX_BITS(3), .I_BITS(12), .Q_BITS(12), .PASS_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
    .busy(busy), .done(done), .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid),
    .i(i), .q(q), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_final(out_final)
  );

  always #5 clk = ~clk;
  assign i = {9'b0, resp_k};
  assign q = 12'd0 - i;

  always @(posedge clk) begin
    s_axi_rvalid <= (m_axi_rvalid && s_axi_rready) || stray;
    resp_k <= m_axi_raddr;
    s_axi_rready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      oq.push_back({out_i, out_q, out_last, out_final});
      tq.push_back(cyc);
    end
    if (m_axi_rvalid && s_axi_rready) aq.push_back(m_axi_raddr);
    if (m_axi_rvalid) rv_cnt <= rv_cnt + 1;
    if (start) st_cyc <= cyc;
    if (done) begin
      done_cnt <= done_cnt + 1;
      dn_cyc <= cyc;
    end
    if (pv && !pr && m_axi_rvalid && m_axi_raddr != pa) stab_err <= stab_err + 1;
    pv <= m_axi_rvalid;
    pr <= s_axi_rready;
    pa <= m_axi_raddr;
  end

  function automatic logic [25:0] exp_word(int n, int np);
    logic [11:0] k;
    k = 12'(n % BL);
    return {k, 12'd0 - k, k == 12'(BL - 1), (k == 12'(BL - 1)) && (n / BL == np - 1)};
  endfunction

  task automatic pulse_start(input logic [7:0] np);
    start = 1;
    num_passes = np;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(output bit ok, input int lim);
    ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      ok = done;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, m_axi_rvalid, m_axi_rready, out_valid, out_last, out_final, out_i, out_q, m_axi_raddr} !== 34'd0)
      $display("FAIL reset_outputs got busy=%b done=%b rv=%b rr=%b ov=%b i=%h q=%h want all 0",
               busy, done, m_axi_rvalid, m_axi_rready, out_valid, out_i, out_q);
    else pass_cnt++;
    reset = 0;
    stray = 1;
    repeat (2) @(posedge clk);
    #1;
    stray = 0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL idle_stray got ov=%b busy=%b want 0 0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int ob, ab, db, gaps;
    bit ok;
    ob = oq.size(); ab = aq.size(); db = done_cnt; gaps = 0;
    pulse_start(1);
    wait_done(ok, 100);
    total++;
    if (!ok) $display("FAIL single_done_timeout got none want done"); else pass_cnt++;
    total++;
    if (oq.size() - ob != 8) $display("FAIL single_count got %0d want 8", oq.size() - ob); else pass_cnt++;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (oq[ob+n] !== exp_word(n, 1)) $display("FAIL single_out[%0d] got %h want %h", n, oq[ob+n], exp_word(n, 1));
      else pass_cnt++;
      total++;
      if (aq[ab+n] !== 3'(n)) $display("FAIL single_addr[%0d] got %0d want %0d", n, aq[ab+n], n);
      else pass_cnt++;
      if (n > 0 && tq[ob+n] - tq[ob+n-1] != 1) gaps++;
    end
    total++;
    if (gaps != 0) $display("FAIL single_gaps got %0d want 0", gaps); else pass_cnt++;
    total++;
    if (tq[ob] - st_cyc != 3) $display("FAIL single_latency got %0d want 3", tq[ob] - st_cyc); else pass_cnt++;
    total++;
    if (dn_cyc - tq[ob+7] != 2) $display("FAIL single_done_time got %0d want 2", dn_cyc - tq[ob+7]); else pass_cnt++;
    total++;
    if (done_cnt - db != 1) $display("FAIL single_done_pulses got %0d want 1", done_cnt - db); else pass_cnt++;
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL single_idle got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_multi_pass;
    int ob, ab, db, gaps;
    bit ok;
    ob = oq.size(); ab = aq.size(); db = done_cnt; gaps = 0;
    pulse_start(3);
    wait_done(ok, 200);
    total++;
    if (!ok) $display("FAIL multi_done_timeout got none want done"); else pass_cnt++;
    total++;
    if (oq.size() - ob != 24) $display("FAIL multi_count got %0d want 24", oq.size() - ob); else pass_cnt++;
    for (int n = 0; n < 24; n++) begin
      total++;
      if (oq[ob+n] !== exp_word(n, 3)) $display("FAIL multi_out[%0d] got %h want %h", n, oq[ob+n], exp_word(n, 3));
      else pass_cnt++;
      total++;
      if (aq[ab+n] !== 3'(n % BL)) $display("FAIL multi_addr[%0d] got %0d want %0d", n, aq[ab+n], n % BL);
      else pass_cnt++;
      if (n > 0 && tq[ob+n] - tq[ob+n-1] != 1) gaps++;
    end
    total++;
    if (gaps != 0) $display("FAIL multi_gaps got %0d want 0", gaps); else pass_cnt++;
    total++;
    if (done_cnt - db != 1) $display("FAIL multi_done_pulses got %0d want 1", done_cnt - db); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int ob, ab, w;
    bit ok;
    ob = oq.size(); ab = aq.size(); w = 0;
    pulse_start(2);
    while (oq.size() - ob < 3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    out_ready = 0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (m_axi_rvalid !== 1'b0) $display("FAIL stall_rvalid got %b want 0", m_axi_rvalid); else pass_cnt++;
    total++;
    if ((aq.size() - ab) - (oq.size() - ob) != 4)
      $display("FAIL stall_credits got %0d want 4", (aq.size() - ab) - (oq.size() - ob));
    else pass_cnt++;
    out_ready = 1;
    wait_done(ok, 200);
    total++;
    if (!ok) $display("FAIL stall_done_timeout got none want done"); else pass_cnt++;
    total++;
    if (oq.size() - ob != 16) $display("FAIL stall_count got %0d want 16", oq.size() - ob); else pass_cnt++;
    for (int n = 0; n < 16; n++) begin
      total++;
      if (oq[ob+n] !== exp_word(n, 2)) $display("FAIL stall_out[%0d] got %h want %h", n, oq[ob+n], exp_word(n, 2));
      else pass_cnt++;
    end
  endtask

  task automatic test_random_ready;
    int ob, se;
    bit ok;
    ob = oq.size(); se = stab_err;
    rand_mode = 1;
    pulse_start(2);
    wait_done(ok, 600);
    rand_mode = 0;
    total++;
    if (!ok) $display("FAIL rand_done_timeout got none want done"); else pass_cnt++;
    total++;
    if (stab_err != se) $display("FAIL rand_addr_stable got %0d changes want 0", stab_err - se); else pass_cnt++;
    total++;
    if (oq.size() - ob != 16) $display("FAIL rand_count got %0d want 16", oq.size() - ob); else pass_cnt++;
    for (int n = 0; n < 16; n++) begin
      total++;
      if (oq[ob+n] !== exp_word(n, 2)) $display("FAIL rand_out[%0d] got %h want %h", n, oq[ob+n], exp_word(n, 2));
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_passes;
    int rb, db;
    rb = rv_cnt; db = done_cnt;
    pulse_start(0);
    total++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy); else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", done); else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (rv_cnt != rb) $display("FAIL zero_rvalid got %0d cycles want 0", rv_cnt - rb); else pass_cnt++;
    total++;
    if (done_cnt - db != 1) $display("FAIL zero_done_pulses got %0d want 1", done_cnt - db); else pass_cnt++;
    total++;
    if (dn_cyc - st_cyc != 1) $display("FAIL zero_done_time got %0d want 1", dn_cyc - st_cyc); else pass_cnt++;
  endtask

  task automatic test_abort;
    int ob, ab, db, w;
    bit ok;
    ob = oq.size(); db = done_cnt; w = 0;
    pulse_start(2);
    while (oq.size() - ob < 5 && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 50) $display("FAIL abort_wait got %0d outputs want 5", oq.size() - ob); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, m_axi_rvalid, m_axi_rready, out_valid, out_last, out_final, out_i, out_q, m_axi_raddr} !== 34'd0)
      $display("FAIL abort_outputs got busy=%b rv=%b ov=%b i=%h q=%h addr=%0d want all 0",
               busy, m_axi_rvalid, out_valid, out_i, out_q, m_axi_raddr);
    else pass_cnt++;
    reset = 0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt != db) $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - db); else pass_cnt++;
    ob = oq.size(); ab = aq.size(); db = done_cnt;
    pulse_start(1);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(3);
    wait_done(ok, 100);
    total++;
    if (!ok) $display("FAIL restart_done_timeout got none want done"); else pass_cnt++;
    total++;
    if (oq.size() - ob != 8) $display("FAIL restart_count got %0d want 8", oq.size() - ob); else pass_cnt++;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (oq[ob+n] !== exp_word(n, 1)) $display("FAIL restart_out[%0d] got %h want %h", n, oq[ob+n], exp_word(n, 1));
      else pass_cnt++;
      total++;
      if (aq[ab+n] !== 3'(n)) $display("FAIL restart_addr[%0d] got %0d want %0d", n, aq[ab+n], n);
      else pass_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt - db != 1) $display("FAIL restart_done_pulses got %0d want 1", done_cnt - db); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi_pass;
    test_backpressure;
    test_random_ready;
    test_zero_passes;
    test_abort;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
